// File: rtl/sram_device_responder_if.sv
// Pin bundle between an SRAM controller (master) and the SRAM device model (slave).
// Strobes ending in _n are active low, as on the physical chip.
interface sram_device_responder_if #(
    parameter int ADDR_W = 21
);
    logic [ADDR_W-1:0] sram_address;
    logic [15:0]       dq_wr;
    logic              cs_n;
    logic              oe_n;
    logic              we_n;
    logic              ub_n;
    logic              lb_n;
    logic [15:0]       dq_rd;
    logic [1:0]        dq_oe;
    logic              ready;
    logic [1:0]        viol;

    modport master (
        output sram_address, dq_wr, cs_n, oe_n, we_n, ub_n, lb_n,
        input  dq_rd, dq_oe, ready, viol
    );

    modport slave (
        input  sram_address, dq_wr, cs_n, oe_n, we_n, ub_n, lb_n,
        output dq_rd, dq_oe, ready, viol
    );
endinterface

// File: rtl/sram_device_responder.sv
// Clocked model of an asynchronous 16-bit SRAM: power-up wait, address-access delay and write-pulse rules.
// Define SRAM_RESP_TIMING_CHECK_EN to discard short write pulses and record sticky violations in viol.
module sram_device_responder #(
    parameter int ADDR_W         = 21,
    parameter int MEM_AW         = 10,
    parameter int POWERUP_CYCLES = 40000,
    parameter int T_AA           = 3,
    parameter int T_WP           = 3
) (
    input logic                   i_clk,
    input logic                   reset,
    sram_device_responder_if.slave bus
);
    localparam int DEPTH   = 2 ** MEM_AW;
    localparam int PWR_W   = $clog2(POWERUP_CYCLES + 1);
    localparam int CNT_MAX = (T_AA > T_WP) ? T_AA : T_WP;
    localparam int CNT_W   = $clog2(CNT_MAX + 1) + 1;

    localparam logic [PWR_W-1:0] PWR_DONE = PWR_W'(POWERUP_CYCLES);
    localparam logic [CNT_W-1:0] CNT_AA   = CNT_W'(T_AA);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
    localparam logic [CNT_W-1:0] CNT_SAT  = '1;

    localparam logic [2:0] S_PWRUP  = 3'd0;
    localparam logic [2:0] S_IDLE   = 3'd1;
    localparam logic [2:0] S_RSETUP = 3'd2;
    localparam logic [2:0] S_RDRIVE = 3'd3;
    localparam logic [2:0] S_WPULSE = 3'd4;

    // With T_AA of one cycle the first sampled cycle already satisfies the access time.
    localparam logic [2:0] S_RD_FIRST = (T_AA <= 1) ? S_RDRIVE : S_RSETUP;

    logic [2:0]        state;
    logic [PWR_W-1:0]  pwr_cnt;
    logic [CNT_W-1:0]  cnt;
    logic [ADDR_W-1:0] addr_q;
    logic [15:0]       wdata_q;
    logic [1:0]        wbe_n_q;
    logic [15:0]       dq_rd_q;
    logic [1:0]        dq_oe_q;
    logic              ready_q;

    logic [15:0]       mem [DEPTH];
    logic [MEM_AW-1:0] idx;
    logic [15:0]       mem_word;
    logic              wr_active;
    logic              rd_request;
    logic              addr_same;
    logic              pulse_ok;
    logic              commit;

    assign idx        = addr_q[MEM_AW-1:0];
    assign mem_word   = mem[idx];
    assign wr_active  = !bus.cs_n && !bus.we_n;
    assign rd_request = !bus.cs_n && !bus.oe_n;
    assign addr_same  = (bus.sram_address == addr_q);

`ifdef SRAM_RESP_TIMING_CHECK_EN
    localparam logic [CNT_W-1:0] CNT_WP = CNT_W'(T_WP);
    logic [1:0] viol_q;
    assign pulse_ok = (cnt >= CNT_WP);
    assign bus.viol = viol_q;
`else
    assign pulse_ok = 1'b1;
    assign bus.viol = 2'b00;
`endif

    // Pulse ends on the first inactive cycle; the registered data from the last active cycle is written.
    assign commit = !reset && (state == S_WPULSE) && !wr_active && pulse_ok;

    // NOTE: sequential state uses non-blocking assignments only, so every register samples pre-edge values.
    always_ff @(posedge i_clk) begin
        if (reset) begin
            state   <= S_PWRUP;
            pwr_cnt <= '0;
            cnt     <= '0;
            addr_q  <= '0;
            wdata_q <= '0;
            wbe_n_q <= 2'b11;
            dq_rd_q <= '0;
            dq_oe_q <= 2'b00;
            ready_q <= 1'b0;
`ifdef SRAM_RESP_TIMING_CHECK_EN
            viol_q  <= 2'b00;
`endif
        end else begin
            dq_rd_q <= '0;
            dq_oe_q <= 2'b00;
            case (state)
                S_PWRUP: begin
`ifdef SRAM_RESP_TIMING_CHECK_EN
                    if (!bus.cs_n) viol_q[0] <= 1'b1;
`endif
                    if (pwr_cnt == PWR_DONE) begin
                        ready_q <= 1'b1;
                        state   <= S_IDLE;
                    end else begin
                        pwr_cnt <= pwr_cnt + 1'b1;
                    end
                end
                S_IDLE: begin
                    if (wr_active) begin
                        state   <= S_WPULSE;
                        cnt     <= CNT_ONE;
                        addr_q  <= bus.sram_address;
                        wdata_q <= bus.dq_wr;
                        wbe_n_q <= {bus.ub_n, bus.lb_n};
                    end else if (rd_request) begin
                        state  <= S_RD_FIRST;
                        cnt    <= CNT_ONE;
                        addr_q <= bus.sram_address;
                    end
                end
                S_RSETUP, S_RDRIVE: begin
                    // WE low wins over OE low: the read is dropped and the pulse starts counting now.
                    if (wr_active) begin
                        state   <= S_WPULSE;
                        cnt     <= CNT_ONE;
                        addr_q  <= bus.sram_address;
                        wdata_q <= bus.dq_wr;
                        wbe_n_q <= {bus.ub_n, bus.lb_n};
                    end else if (!rd_request) begin
                        state <= S_IDLE;
                    end else if (!addr_same) begin
                        state  <= S_RD_FIRST;
                        cnt    <= CNT_ONE;
                        addr_q <= bus.sram_address;
                    end else if (state == S_RSETUP) begin
                        cnt <= cnt + 1'b1;
                        if (cnt + 1'b1 == CNT_AA) state <= S_RDRIVE;
                    end else begin
                        dq_oe_q <= {!bus.ub_n, !bus.lb_n};
                        dq_rd_q <= {bus.ub_n ? 8'h00 : mem_word[15:8],
                                    bus.lb_n ? 8'h00 : mem_word[7:0]};
                    end
                end
                S_WPULSE: begin
                    if (wr_active) begin
                        addr_q  <= bus.sram_address;
                        wdata_q <= bus.dq_wr;
                        wbe_n_q <= {bus.ub_n, bus.lb_n};
                        if (cnt != CNT_SAT) cnt <= cnt + 1'b1;
                    end else begin
`ifdef SRAM_RESP_TIMING_CHECK_EN
                        if (!pulse_ok) viol_q[1] <= 1'b1;
`endif
                        state <= S_IDLE;
                    end
                end
                default: state <= S_PWRUP;
            endcase
        end
    end

    // NOTE: the array has no reset term; contents survive reset and it stays mappable to block RAM.
    always_ff @(posedge i_clk) begin
        if (commit) begin
            if (!wbe_n_q[1]) mem[idx][15:8] <= wdata_q[15:8];
            if (!wbe_n_q[0]) mem[idx][7:0]  <= wdata_q[7:0];
        end
    end

    assign bus.dq_rd = dq_rd_q;
    assign bus.dq_oe = dq_oe_q;
    assign bus.ready = ready_q;
endmodule

// File: tb/tb_sram_device_responder.sv
// Directed bench for sram_device_responder: power-up, byte-lane writes/reads, read restart, short pulses, reset abort.
// Expectations follow SRAM_RESP_TIMING_CHECK_EN when it is defined for the build.
module tb_sram_device_responder;
    localparam int ADDR_W = 21;
    localparam int P      = 200;
    localparam int T_AA   = 3;

`ifdef SRAM_RESP_TIMING_CHECK_EN
    localparam logic [15:0] SHORT_EXP  = 16'hBE34;
    localparam logic [1:0]  VIOL_SHORT = 2'b10;
    localparam logic [1:0]  VIOL_PWR   = 2'b01;
`else
    localparam logic [15:0] SHORT_EXP  = 16'hAAAA;
    localparam logic [1:0]  VIOL_SHORT = 2'b00;
    localparam logic [1:0]  VIOL_PWR   = 2'b00;
`endif

    typedef struct {
        logic              cs_n;
        logic              oe_n;
        logic              we_n;
        logic              ub_n;
        logic              lb_n;
        logic [ADDR_W-1:0] addr;
        logic [15:0]       dq;
        logic [1:0]        exp_oe;
        logic [15:0]       exp_dq;
    } vec_t;

    logic clk;
    logic reset;
    int   n_tests = 0;
    int   n_fail  = 0;
    vec_t vecs[$];

    sram_device_responder_if #(.ADDR_W(ADDR_W)) bus();

    sram_device_responder #(
        .ADDR_W(ADDR_W), .MEM_AW(10), .POWERUP_CYCLES(P), .T_AA(T_AA), .T_WP(3)
    ) dut (
        .i_clk(clk),
        .reset(reset),
        .bus(bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic cs_n, input logic oe_n, input logic we_n, input logic ub_n,
                         input logic lb_n, input logic [ADDR_W-1:0] addr, input logic [15:0] dq);
        bus.cs_n = cs_n; bus.oe_n = oe_n; bus.we_n = we_n;
        bus.ub_n = ub_n; bus.lb_n = lb_n;
        bus.sram_address = addr; bus.dq_wr = dq;
    endtask

    task automatic push(input logic cs_n, input logic oe_n, input logic we_n, input logic ub_n,
                        input logic lb_n, input logic [ADDR_W-1:0] addr, input logic [15:0] dq,
                        input logic [1:0] exp_oe, input logic [15:0] exp_dq);
        vec_t v;
        v.cs_n = cs_n; v.oe_n = oe_n; v.we_n = we_n; v.ub_n = ub_n; v.lb_n = lb_n;
        v.addr = addr; v.dq = dq; v.exp_oe = exp_oe; v.exp_dq = exp_dq;
        vecs.push_back(v);
    endtask

    task automatic push_idle();
        push(1'b1, 1'b1, 1'b1, 1'b0, 1'b0, '0, 16'h0000, 2'b00, 16'h0000);
    endtask

    task automatic push_write(input logic [ADDR_W-1:0] addr, input logic [15:0] dq,
                              input logic ub_n, input logic lb_n, input int n);
        for (int i = 0; i < n; i++) push(1'b0, 1'b1, 1'b0, ub_n, lb_n, addr, dq, 2'b00, 16'h0000);
        push_idle();
    endtask

    // T_AA quiet cycles, then the first driven cycle; the read stays open.
    task automatic push_read(input logic [ADDR_W-1:0] addr, input logic ub_n, input logic lb_n,
                             input logic [1:0] exp_oe, input logic [15:0] exp_dq);
        for (int i = 0; i < T_AA; i++) push(1'b0, 1'b0, 1'b1, ub_n, lb_n, addr, 16'h0000, 2'b00, 16'h0000);
        push(1'b0, 1'b0, 1'b1, ub_n, lb_n, addr, 16'h0000, exp_oe, exp_dq);
    endtask

    initial begin
        int waited;

        // Full write then full read.
        push_write(21'h1A2B5, 16'hBEEF, 1'b0, 1'b0, 3);
        push_read(21'h1A2B5, 1'b0, 1'b0, 2'b11, 16'hBEEF);
        push(1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 21'h1A2B5, 16'h0000, 2'b11, 16'hBEEF);
        push_idle();
        // Lower-lane write, then lane enables changed while the read is held.
        push_write(21'h1A2B5, 16'h1234, 1'b1, 1'b0, 3);
        push_read(21'h1A2B5, 1'b0, 1'b0, 2'b11, 16'hBE34);
        push(1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 21'h1A2B5, 16'h0000, 2'b10, 16'hBE00);
        push(1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 21'h1A2B5, 16'h0000, 2'b01, 16'h0034);
        push_idle();
        // Address change mid-read restarts the access time.
        push_write(21'h00010, 16'h1111, 1'b0, 1'b0, 3);
        push_write(21'h00011, 16'h2222, 1'b0, 1'b0, 3);
        push_read(21'h00010, 1'b0, 1'b0, 2'b11, 16'h1111);
        push_read(21'h00011, 1'b0, 1'b0, 2'b11, 16'h2222);
        push_idle();
        // Upper address bits alias.
        push_read(21'h00410, 1'b0, 1'b0, 2'b11, 16'h1111);
        push_idle();
        // WE falling during a driven read turns the lanes off and writes.
        push_read(21'h00010, 1'b0, 1'b0, 2'b11, 16'h1111);
        push_write(21'h00010, 16'h5555, 1'b0, 1'b0, 0);
        vecs.pop_back();
        for (int i = 0; i < 3; i++) push(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 21'h00010, 16'h5555, 2'b00, 16'h0000);
        push_idle();
        push_read(21'h00010, 1'b0, 1'b0, 2'b11, 16'h5555);
        push_idle();
        // Two-cycle pulse.
        push_write(21'h1A2B5, 16'hAAAA, 1'b0, 1'b0, 2);
        push_read(21'h1A2B5, 1'b0, 1'b0, 2'b11, SHORT_EXP);
        push_idle();

        // Reset and power-up wait.
        drive(1'b1, 1'b1, 1'b1, 1'b0, 1'b0, '0, 16'h0000);
        reset = 1'b1;
        step();
        step();
        check("rst_dq", 32'(bus.dq_rd), 32'h0);
        check("rst_oe", 32'(bus.dq_oe), 32'h0);
        check("rst_ready", 32'(bus.ready), 32'h0);
        check("rst_viol", 32'(bus.viol), 32'h0);
        reset = 1'b0;
        for (int i = 0; i < P; i++) begin
            step();
            check($sformatf("pwrup_ready_c%0d", i + 1), 32'(bus.ready), 32'h0);
            check($sformatf("pwrup_oe_c%0d", i + 1), 32'(bus.dq_oe), 32'h0);
        end
        step();
        check("pwrup_ready_done", 32'(bus.ready), 32'h1);

        for (int i = 0; i < vecs.size(); i++) begin
            drive(vecs[i].cs_n, vecs[i].oe_n, vecs[i].we_n, vecs[i].ub_n, vecs[i].lb_n,
                  vecs[i].addr, vecs[i].dq);
            step();
            check($sformatf("vec%0d_oe", i), 32'(bus.dq_oe), 32'(vecs[i].exp_oe));
            if (vecs[i].exp_oe != 2'b00)
                check($sformatf("vec%0d_dq", i), 32'(bus.dq_rd), 32'(vecs[i].exp_dq));
        end
        check("short_pulse_viol", 32'(bus.viol), 32'(VIOL_SHORT));

        // Reset in the middle of a write pulse.
        drive(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 21'h1A2B5, 16'h7777);
        step();
        step();
        reset = 1'b1;
        step();
        drive(1'b1, 1'b1, 1'b1, 1'b0, 1'b0, '0, 16'h0000);
        reset = 1'b0;
        check("abort_ready", 32'(bus.ready), 32'h0);
        check("abort_oe", 32'(bus.dq_oe), 32'h0);
        check("abort_viol", 32'(bus.viol), 32'h0);

        // Chip select at power-up cycle 100.
        for (int i = 0; i < 99; i++) step();
        bus.cs_n = 1'b0;
        step();
        bus.cs_n = 1'b1;
        check("pwrup_access_viol", 32'(bus.viol), 32'(VIOL_PWR));
        check("pwrup_access_oe", 32'(bus.dq_oe), 32'h0);

        waited = 0;
        while (!bus.ready && waited < P + 10) begin
            step();
            waited++;
        end
        check("pwrup2_ready", 32'(bus.ready), 32'h1);
        check("pwrup2_edges", 32'(waited), 32'(P + 1 - 100));

        drive(1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 21'h1A2B5, 16'h0000);
        for (int i = 0; i < T_AA; i++) begin
            step();
            check($sformatf("abort_rd_wait%0d", i), 32'(bus.dq_oe), 32'h0);
        end
        step();
        check("abort_rd_oe", 32'(bus.dq_oe), 32'h3);
        check("abort_rd_dq", 32'(bus.dq_rd), 32'(SHORT_EXP));
        check("viol_sticky", 32'(bus.viol), 32'(VIOL_PWR));
        drive(1'b1, 1'b1, 1'b1, 1'b0, 1'b0, '0, 16'h0000);
        step();
        check("final_oe", 32'(bus.dq_oe), 32'h0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
